// File: rtl/lstm_transpose_mac.sv
// Streaming transposed matrix-vector product for LSTM gradient back-propagation:
// buffers one gradient vector, then emits y[r] = sum_c W[r][c]*g[c] per streamed weight row.
module lstm_transpose_mac #(
    parameter int ROWS = 100,
    parameter int COLS = 400,
    parameter int DW   = 32,
    parameter int ACCW = 73,
    parameter int FRAC = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    input  logic                 g_valid,
    output logic                 g_ready,
    input  logic signed [DW-1:0] g_data,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic signed [DW-1:0] w_data,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic signed [DW-1:0] y_data,
    output logic                 y_last,
    output logic                 done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_G = 2'd1,
        MAC    = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t                 state_r, state_next_s;
    logic [CW-1:0]          col_r, col_next_s;
    logic [RW-1:0]          row_r, row_next_s;
    logic signed [ACCW-1:0] acc_r, acc_next_s;
    logic signed [DW-1:0]   gbuf_r [COLS];
    logic signed [2*DW-1:0] prod_s;
    logic                   g_wr_s, y_load_s, done_next_s;
    logic                   busy_r, g_ready_r, w_ready_r, y_valid_r, y_last_r, done_r;
    logic signed [DW-1:0]   y_data_r;

    // Scale by FRAC (arithmetic shift, floors toward minus infinity) then clamp to DW bits.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] s;
        s = v >>> FRAC;
        if (s > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end else begin
            return s[DW-1:0];
        end
    endfunction

    assign prod_s = w_data * gbuf_r[col_r];

    // Next-state, counter and accumulator logic.
    always_comb begin
        state_next_s = state_r;
        col_next_s   = col_r;
        row_next_s   = row_r;
        acc_next_s   = acc_r;
        g_wr_s       = 1'b0;
        y_load_s     = 1'b0;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = LOAD_G;
                    col_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD_G: begin
                if (g_valid && g_ready_r) begin
                    g_wr_s = 1'b1;
                    if (col_r == COL_LAST) begin
                        state_next_s = MAC;
                        col_next_s   = '0;
                        row_next_s   = '0;
                        acc_next_s   = '0;
                    end else begin
                        col_next_s = col_r + CW'(1);
                    end
                end else begin
                    state_next_s = LOAD_G;
                end
            end
            MAC: begin
                if (w_valid && w_ready_r) begin
                    acc_next_s = acc_r + ACCW'(prod_s);
                    if (col_r == COL_LAST) begin
                        state_next_s = EMIT;
                        y_load_s     = 1'b1;
                    end else begin
                        col_next_s = col_r + CW'(1);
                    end
                end else begin
                    state_next_s = MAC;
                end
            end
            EMIT: begin
                if (y_ready) begin
                    if (row_r == ROW_LAST) begin
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = MAC;
                        row_next_s   = row_r + RW'(1);
                        col_next_s   = '0;
                        acc_next_s   = '0;
                    end
                end else begin
                    state_next_s = EMIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counters, accumulator and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            col_r     <= '0;
            row_r     <= '0;
            acc_r     <= '0;
            busy_r    <= 1'b0;
            g_ready_r <= 1'b0;
            w_ready_r <= 1'b0;
            y_valid_r <= 1'b0;
            y_data_r  <= '0;
            y_last_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            col_r     <= col_next_s;
            row_r     <= row_next_s;
            acc_r     <= acc_next_s;
            busy_r    <= (state_next_s != IDLE);
            g_ready_r <= (state_next_s == LOAD_G);
            w_ready_r <= (state_next_s == MAC);
            y_valid_r <= (state_next_s == EMIT);
            done_r    <= done_next_s;
            if (y_load_s) begin
                y_data_r <= sat_dw(acc_next_s);
                y_last_r <= (row_r == ROW_LAST);
            end
        end
    end

    // Gradient buffer; contents are meaningless until reloaded, so no reset.
    always_ff @(posedge clk) begin
        if (g_wr_s) begin
            gbuf_r[col_r] <= g_data;
        end
    end

    assign busy    = busy_r;
    assign g_ready = g_ready_r;
    assign w_ready = w_ready_r;
    assign y_valid = y_valid_r;
    assign y_data  = y_data_r;
    assign y_last  = y_last_r;
    assign done    = done_r;

endmodule
